// File: rtl/chip_emulator_if.sv
// DIP-14 pin bundle between the chip checker (master) and the emulated part (slave).
interface chip_emulator_if;
  logic [13:0] PinIn;
  logic [13:0] PinOut;
  logic [13:0] PinOE;

  modport master (output PinIn, input PinOut, input PinOE);
  modport slave  (input PinIn, output PinOut, output PinOE);
endinterface

// File: rtl/chip_emulator.sv
// Emulated DIP-14 part (7400 / 7402 / 7474) behind a 2-flop input synchronizer,
// with stuck-at fault injection, a programmable output delay line and an event counter.

module chip_emulator_dff (
  input  logic Clk,
  input  logic Reset,
  input  logic flush,
  input  logic clr_n,
  input  logic pre_n,
  input  logic d,
  input  logic ck,
  output logic q_nxt,
  output logic qn_nxt
);
  logic q, ck_prev, both_low;

  assign both_low = ~clr_n & ~pre_n;

  always_comb begin
    q_nxt = q;
    if (both_low)              q_nxt = 1'b1;
    else if (!clr_n)           q_nxt = 1'b0;
    else if (!pre_n)           q_nxt = 1'b1;
    else if (ck && !ck_prev)   q_nxt = d;
    qn_nxt = both_low ? 1'b1 : ~q_nxt;
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      q       <= 1'b0;
      ck_prev <= 1'b0;
    end else begin
      ck_prev <= ck;
      q       <= flush ? 1'b0 : q_nxt;
    end
  end
endmodule

module chip_emulator #(
  parameter int PROP_DLY = 2,
  parameter int CNT_W    = 16
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic [1:0]        Chip_Sel,
  chip_emulator_if.slave    pins,
  input  logic              Fault_En,
  input  logic [3:0]        Fault_Pin,
  input  logic              Fault_Val,
  output logic [CNT_W-1:0]  Evt_Cnt
);
  localparam int NP  = 14;
  localparam int NFF = 2;
  localparam logic [1:0] SEL_7400 = 2'd1, SEL_7402 = 2'd2, SEL_7474 = 2'd3;

  logic [NP-1:0]  sync1, s, oe, vec_in, dly_out, pout_nxt;
  logic [1:0]     sel_q;
  logic           flush;
  logic [3:0]     f_idx;
  logic [NFF-1:0] ff_clr_n, ff_pre_n, ff_d, ff_ck, ff_q, ff_qn;
  logic           unused_pwr;

  function automatic logic [NP-1:0] oe_map(input logic [1:0] sel);
    oe_map = '0;
    case (sel)
      SEL_7400: begin oe_map[2] = 1'b1; oe_map[5] = 1'b1; oe_map[7]  = 1'b1; oe_map[10] = 1'b1; end
      SEL_7402: begin oe_map[0] = 1'b1; oe_map[3] = 1'b1; oe_map[9]  = 1'b1; oe_map[12] = 1'b1; end
      SEL_7474: begin oe_map[4] = 1'b1; oe_map[5] = 1'b1; oe_map[7]  = 1'b1; oe_map[8]  = 1'b1; end
      default: ;
    endcase
  endfunction

  // A part swap restarts everything downstream of the synchronizer.
  assign flush      = (Chip_Sel != sel_q);
  assign oe         = oe_map(sel_q);
  assign pins.PinOE = Reset ? '0 : oe;
  assign unused_pwr = s[6] ^ s[13];

  // 7474 pinout: FF1 CLR_n=1 D=2 CLK=3 PRE_n=4; FF2 CLR_n=13 D=12 CLK=11 PRE_n=10
  assign ff_clr_n = {s[12], s[0]};
  assign ff_d     = {s[11], s[1]};
  assign ff_ck    = {s[10], s[2]};
  assign ff_pre_n = {s[9],  s[3]};

  for (genvar g = 0; g < NFF; g++) begin : g_ff
    chip_emulator_dff u_ff (
      .Clk    (Clk),
      .Reset  (Reset),
      .flush  (flush),
      .clr_n  (ff_clr_n[g]),
      .pre_n  (ff_pre_n[g]),
      .d      (ff_d[g]),
      .ck     (ff_ck[g]),
      .q_nxt  (ff_q[g]),
      .qn_nxt (ff_qn[g])
    );
  end

  always_comb begin
    vec_in = '0;
    case (sel_q)
      SEL_7400: begin
        vec_in[2]  = ~(s[0]  & s[1]);
        vec_in[5]  = ~(s[3]  & s[4]);
        vec_in[7]  = ~(s[8]  & s[9]);
        vec_in[10] = ~(s[11] & s[12]);
      end
      SEL_7402: begin
        vec_in[0]  = ~(s[1]  | s[2]);
        vec_in[3]  = ~(s[4]  | s[5]);
        vec_in[9]  = ~(s[7]  | s[8]);
        vec_in[12] = ~(s[10] | s[11]);
      end
      SEL_7474: begin
        vec_in[4] = ff_q[0];
        vec_in[5] = ff_qn[0];
        vec_in[8] = ff_q[1];
        vec_in[7] = ff_qn[1];
      end
      default: ;
    endcase
    // Pin 0 maps to index 15 and never matches, so only pins 1..14 can fault.
    f_idx = Fault_Pin - 4'd1;
    for (int i = 0; i < NP; i++)
      if (Fault_En && oe[i] && (f_idx == 4'(i))) vec_in[i] = Fault_Val;
  end

  if (PROP_DLY == 0) begin : g_nodly
    assign dly_out = vec_in;
  end else begin : g_dly
    logic [PROP_DLY-1:0][NP-1:0] sr;
    always_ff @(posedge Clk) begin
      if (Reset || flush) begin
        sr <= '0;
      end else begin
        sr[0] <= vec_in;
        for (int i = 1; i < PROP_DLY; i++) sr[i] <= sr[i-1];
      end
    end
    assign dly_out = sr[PROP_DLY-1];
  end

  assign pout_nxt = flush ? '0 : (dly_out & oe);

  always_ff @(posedge Clk) begin
    if (Reset) begin
      sync1       <= '0;
      s           <= '0;
      sel_q       <= '0;
      pins.PinOut <= '0;
      Evt_Cnt     <= '0;
    end else begin
      sync1       <= pins.PinIn;
      s           <= sync1;
      sel_q       <= Chip_Sel;
      pins.PinOut <= pout_nxt;
      if ((pout_nxt != pins.PinOut) && (Evt_Cnt != '1)) Evt_Cnt <= Evt_Cnt + CNT_W'(1);
    end
  end
endmodule
